// File: rtl/pad_pok_sequencer.sv
// Pad-ring power-ok sequencer: synchronizes raw rail power-good, debounces it
// and releases per-bank pad power-ok in ascending bank order with a settle delay.
package pad_pok_pkg;
  typedef logic [7:0] pad_pok_t;
endpackage

module pad_pok_sequencer
  import pad_pok_pkg::*;
#(
  parameter int NumBanks       = 4,
  parameter int DebounceCycles = 16,
  parameter int SettleCycles   = 8
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               en_i,
  input  pad_pok_t [NumBanks-1:0]                            raw_pok_i,
  output pad_pok_t [NumBanks-1:0]                            pad_pok_o,
  output logic [NumBanks-1:0]                                released_o,
  output logic [((NumBanks > 1) ? $clog2(NumBanks) : 1)-1:0] cur_bank_o,
  output logic                                               all_ok_o,
  output logic                                               fault_o
);

  localparam int CurW   = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int CntMax = (DebounceCycles > SettleCycles) ? DebounceCycles : SettleCycles;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DebLast  = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] SetLast  = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};
  localparam logic [CurW-1:0] LastBank = CurW'(NumBanks - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t                  state, state_n;
  logic [CurW-1:0]         cur, cur_n;
  logic [CntW-1:0]         cnt, cnt_n, cnt_inc;
  logic [NumBanks-1:0]     released, released_n;
  logic [NumBanks-1:0]     bank_good;
  logic                    fault_q, fault_n;
  logic                    fault_any;
  logic [CurW-1:0]         fault_bank;
  pad_pok_t [NumBanks-1:0] raw_meta, raw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_meta <= '0;
      raw_sync <= '0;
    end else begin
      raw_meta <= raw_pok_i;
      raw_sync <= raw_meta;
    end
  end

  always_comb begin
    bank_good = '0;
    for (int b = 0; b < NumBanks; b++) begin
      bank_good[b] = &raw_sync[b];
    end
  end

  // Descending scan so the lowest failing released bank wins.
  always_comb begin
    fault_any  = 1'b0;
    fault_bank = '0;
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (released[b] && !bank_good[b]) begin
        fault_any  = 1'b1;
        fault_bank = CurW'(b);
      end
    end
  end

  assign cnt_inc = (cnt == CntSat) ? cnt : cnt + CntW'(1);

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    cnt_n      = cnt;
    released_n = released;
    fault_n    = 1'b0;
    if (!en_i) begin
      state_n    = ST_IDLE;
      cur_n      = '0;
      cnt_n      = '0;
      released_n = '0;
    end else if (state != ST_IDLE && fault_any) begin
      // Revoke the failing bank and everything above it, then resequence from it.
      for (int b = 0; b < NumBanks; b++) begin
        if (CurW'(b) >= fault_bank) begin
          released_n[b] = 1'b0;
        end
      end
      cur_n   = fault_bank;
      cnt_n   = '0;
      state_n = ST_WAIT;
      fault_n = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_WAIT;
          cur_n   = '0;
          cnt_n   = '0;
        end
        ST_WAIT: begin
          if (!bank_good[cur]) begin
            cnt_n = '0;
          end else if (cnt == DebLast) begin
            state_n = ST_SETTLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_SETTLE: begin
          if (!bank_good[cur]) begin
            state_n = ST_WAIT;
            cnt_n   = '0;
          end else if (cnt == SetLast) begin
            released_n[cur] = 1'b1;
            cnt_n           = '0;
            if (cur == LastBank) begin
              state_n = ST_DONE;
            end else begin
              cur_n   = cur + CurW'(1);
              state_n = ST_WAIT;
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_DONE: begin
          state_n = ST_DONE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur      <= '0;
      cnt      <= '0;
      released <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      cnt      <= cnt_n;
      released <= released_n;
      fault_q  <= fault_n;
    end
  end

  always_comb begin
    pad_pok_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      pad_pok_o[b] = released[b] ? raw_sync[b] : 8'h00;
    end
  end

  assign released_o = released;
  assign cur_bank_o = cur;
  assign all_ok_o   = (state == ST_DONE);
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_pad_pok_sequencer.sv
// Testbench for pad_pok_sequencer: directed release/fault/reset scenarios plus
// randomized rail and enable activity, scored against a streak-based model.
module tb_pad_pok_sequencer;
  import pad_pok_pkg::*;

  localparam int NB  = 4;
  localparam int DEB = 16;
  localparam int SET = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  pad_pok_t [NB-1:0] raw_pok;
  pad_pok_t [NB-1:0] pad_pok;
  logic [NB-1:0]     released;
  logic [1:0]        cur_bank;
  logic              all_ok;
  logic              fault;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic [NB-1:0]   rel;
    logic [1:0]      cur;
    logic            ok;
    logic            flt;
    logic [NB*8-1:0] pok;
  } expect_t;

  expect_t exp_q[$];

  pad_pok_sequencer #(
    .NumBanks      (NB),
    .DebounceCycles(DEB),
    .SettleCycles  (SET)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .raw_pok_i (raw_pok),
    .pad_pok_o (pad_pok),
    .released_o(released),
    .cur_bank_o(cur_bank),
    .all_ok_o  (all_ok),
    .fault_o   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input pad_pok_t [NB-1:0] raw_v, input int cycles);
    en      = en_v;
    raw_pok = raw_v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Reference model: released banks always form a prefix of length m_nrel, and the
  // current bank releases after DEB+SET consecutive good edges.
  pad_pok_t [NB-1:0] m_sync1, m_sync2;
  bit      m_active;
  int      m_nrel;
  int      m_streak;
  bit      m_fault;
  int      m_fb;
  expect_t m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1  = '0;
      m_sync2  = '0;
      m_active = 0;
      m_nrel   = 0;
      m_streak = 0;
      m_fault  = 0;
      exp_q.delete();
    end else begin
      m_fb = -1;
      for (int b = m_nrel - 1; b >= 0; b--) begin
        if (!(&m_sync2[b])) m_fb = b;
      end
      m_fault = 0;
      if (!en) begin
        m_active = 0;
        m_nrel   = 0;
        m_streak = 0;
      end else if (!m_active) begin
        m_active = 1;
        m_nrel   = 0;
        m_streak = 0;
      end else if (m_fb >= 0) begin
        m_nrel   = m_fb;
        m_streak = 0;
        m_fault  = 1;
      end else if (m_nrel < NB) begin
        m_streak = (&m_sync2[m_nrel]) ? m_streak + 1 : 0;
        if (m_streak == DEB + SET) begin
          m_nrel++;
          m_streak = 0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = raw_pok;
    end
    m_e.rel = '0;
    m_e.pok = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < m_nrel) begin
        m_e.rel[b]        = 1'b1;
        m_e.pok[b*8 +: 8] = m_sync2[b];
      end
    end
    m_e.cur = 2'((m_nrel < NB) ? m_nrel : NB - 1);
    m_e.ok  = m_active && (m_nrel == NB);
    m_e.flt = m_fault;
    exp_q.push_back(m_e);
  end

  always @(negedge clk) begin
    expect_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("mon_released", 32'(released), 32'(e.rel));
      checkOutput("mon_pad_pok", 32'(pad_pok), 32'(e.pok));
      checkOutput("mon_cur_bank", 32'(cur_bank), 32'(e.cur));
      checkOutput("mon_all_ok", 32'(all_ok), 32'(e.ok));
      checkOutput("mon_fault", 32'(fault), 32'(e.flt));
    end
  end

  initial begin
    #1_000_000;
    error_count++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  initial begin
    pad_pok_t [NB-1:0] all_ff;
    pad_pok_t [NB-1:0] raw_v;
    logic               en_v;

    all_ff  = {NB{8'hFF}};
    rst_n   = 1'b0;
    en      = 1'b0;
    raw_pok = all_ff;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_released", 32'(released), 32'h0);
    checkOutput("reset_pad_pok", 32'(pad_pok), 32'h0);
    checkOutput("reset_cur", 32'(cur_bank), 32'h0);
    checkOutput("reset_all_ok", 32'(all_ok), 32'h0);
    checkOutput("reset_fault", 32'(fault), 32'h0);
    rst_n = 1'b1;

    applyStimulus(1'b0, all_ff, 100);
    checkOutput("idle100_released", 32'(released), 32'h0);
    checkOutput("idle100_pad_pok", 32'(pad_pok), 32'h0);

    // en goes high just after edge e0, so the edge sampling it is e0+1.
    applyStimulus(1'b1, all_ff, 24);
    checkOutput("seq_e24", 32'(released), 32'h0);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("seq_e25", 32'(released), 32'h1);
    checkOutput("seq_e25_pok", 32'(pad_pok), 32'h0000_00FF);
    applyStimulus(1'b1, all_ff, 24);
    checkOutput("seq_e49", 32'(released), 32'h3);
    applyStimulus(1'b1, all_ff, 24);
    checkOutput("seq_e73", 32'(released), 32'h7);
    applyStimulus(1'b1, all_ff, 23);
    checkOutput("seq_e96_all_ok", 32'(all_ok), 32'h0);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("seq_e97", 32'(released), 32'hF);
    checkOutput("seq_e97_all_ok", 32'(all_ok), 32'h1);
    checkOutput("seq_e97_pok", 32'(pad_pok), 32'hFFFF_FFFF);

    raw_v    = all_ff;
    raw_v[2] = 8'hFE;
    applyStimulus(1'b1, raw_v, 2);
    checkOutput("fault_partial_pok", 32'(pad_pok[2]), 32'hFE);
    checkOutput("fault_pre_released", 32'(released), 32'hF);
    applyStimulus(1'b1, raw_v, 1);
    checkOutput("fault_released", 32'(released), 32'h3);
    checkOutput("fault_pulse", 32'(fault), 32'h1);
    checkOutput("fault_cur", 32'(cur_bank), 32'h2);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("fault_pulse_end", 32'(fault), 32'h0);
    // Two synchronizer edges before the bank looks good again, then 24 good edges.
    applyStimulus(1'b1, all_ff, 24);
    checkOutput("rerel_b2_early", 32'(released), 32'h3);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("rerel_b2", 32'(released), 32'h7);
    applyStimulus(1'b1, all_ff, 23);
    checkOutput("rerel_b3_early", 32'(all_ok), 32'h0);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("rerel_b3", 32'(released), 32'hF);
    checkOutput("rerel_all_ok", 32'(all_ok), 32'h1);

    applyStimulus(1'b0, all_ff, 3);
    for (int c = 0; c < 160; c++) begin
      raw_v    = all_ff;
      raw_v[1] = (c % 10 == 0) ? 8'hF7 : 8'hFF;
      applyStimulus(1'b1, raw_v, 1);
    end
    checkOutput("glitch_released", 32'(released), 32'h1);
    checkOutput("glitch_cur", 32'(cur_bank), 32'h1);
    applyStimulus(1'b1, all_ff, 110);
    checkOutput("glitch_recover_all_ok", 32'(all_ok), 32'h1);

    raw_v    = all_ff;
    raw_v[0] = 8'h00;
    applyStimulus(1'b1, raw_v, 2);
    applyStimulus(1'b0, raw_v, 1);
    checkOutput("en_drop_released", 32'(released), 32'h0);
    checkOutput("en_drop_fault", 32'(fault), 32'h0);
    checkOutput("en_drop_all_ok", 32'(all_ok), 32'h0);
    checkOutput("en_drop_cur", 32'(cur_bank), 32'h0);
    applyStimulus(1'b0, all_ff, 3);

    applyStimulus(1'b1, all_ff, 68);
    checkOutput("pre_rst_released", 32'(released), 32'h3);
    checkOutput("pre_rst_cur", 32'(cur_bank), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_released", 32'(released), 32'h0);
    checkOutput("async_rst_pok", 32'(pad_pok), 32'h0);
    checkOutput("async_rst_cur", 32'(cur_bank), 32'h0);
    checkOutput("async_rst_all_ok", 32'(all_ok), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, all_ff, 25);
    checkOutput("post_rst_e25", 32'(released), 32'h0);
    checkOutput("post_rst_cur", 32'(cur_bank), 32'h0);
    applyStimulus(1'b1, all_ff, 1);
    checkOutput("post_rst_e26", 32'(released), 32'h1);

    raw_v = all_ff;
    en_v  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (en_v && $urandom_range(0, 299) == 0) en_v = 1'b0;
      else if (!en_v && $urandom_range(0, 9) == 0) en_v = 1'b1;
      for (int b = 0; b < NB; b++) begin
        if (raw_v[b] == 8'hFF) begin
          if ($urandom_range(0, 299) == 0) raw_v[b] = 8'($urandom_range(0, 254));
        end else if ($urandom_range(0, 3) == 0) begin
          raw_v[b] = 8'hFF;
        end
      end
      applyStimulus(en_v, raw_v, 1);
    end
    applyStimulus(en_v, raw_v, 2);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
